serv_rf_ram_bridge: RTL and testbench
=====================================

Name: serv_rf_ram_bridge

Overview:
- Downstream consumer of the core's register-file port (6-bit wreg0/wreg1/rreg0/rreg1).
- Packs bit-serial register writes into W-bit RAM words.
- Reads both source registers from RAM and streams them back bit-serially, LSB first.
- Sits between serv_top and a simple dual-port (1R+1W) register RAM with 1-cycle read latency.

Parameters:
W, 2, RAM data width; legal values 2,4,8,16,32
CSR_REGS, 4, extra registers above x31; total registers NREG=32+CSR_REGS
AW, derived, RAM address width = clog2(NREG*32/W); address = {reg[5:0], word index}

Ports:
clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_wreq  in  1  one-cycle pulse: start 32-bit serial write window
i_wreg0  in  6  write register, channel 0 (rd); sampled on i_wreq
i_wreg1  in  6  write register, channel 1 (CSR); sampled on i_wreq
i_wen0  in  1  channel 0 enable; sampled on i_wreq
i_wen1  in  1  channel 1 enable; sampled on i_wreq
i_wdata0  in  1  channel 0 serial data
i_wdata1  in  1  channel 1 serial data
o_wbusy  out  1  write window or pending RAM writes active
i_rreq  in  1  one-cycle pulse: start read of two registers
i_rreg0  in  6  read register 0 (rs1); sampled on i_rreq
i_rreg1  in  6  read register 1 (rs2); sampled on i_rreq
o_ready  out  1  one-cycle pulse: serial read data starts next cycle
o_rdata0  out  1  rs1 serial bit
o_rdata1  out  1  rs2 serial bit
o_waddr  out  AW  RAM write address
o_wdata  out  W  RAM write data
o_wen  out  1  RAM write strobe
o_raddr  out  AW  RAM read address
o_ren  out  1  RAM read strobe
i_rdata  in  W  RAM read data, valid the cycle after o_ren

Behaviour:
- Reset: all outputs 0; both FSMs IDLE; bit counters 0. Reset mid-operation aborts both windows; no RAM access is issued in the cycle after i_rst.
- Write FSM (IDLE, SHIFT, FLUSH):
  - i_wreq in IDLE at cycle T latches regs/enables; SHIFT samples i_wdata0/1 at T+1..T+32, bit i at T+1+i, into per-channel W-bit shift buffers.
  - After every W bits, channel 0 word written in the next cycle, channel 1 word the cycle after (o_wen, o_waddr={reg,k}).
  - FLUSH covers the last two writes; last write by T+34. o_wbusy high T+1..T+34 inclusive.
  - Channel write suppressed if its enable=0, or channel 0 reg=0 (x0).
  - Reg index >= NREG: write suppressed.
- Read FSM (IDLE, FETCH, STREAM):
  - i_rreq in IDLE at cycle T: RAM reads rs1 word0 at T+1, rs2 word0 at T+2.
  - o_ready pulse at T+3. Bit i of both registers driven on o_rdata0/1 during cycle T+4+i, i=0..31.
  - Next words prefetched so streaming is gapless: per word index, reads issued rs1 then rs2.
  - Returns to IDLE after T+35; o_rdata0/1 = 0 outside the stream.
  - Reg 0 reads as all zeros regardless of RAM.
- Simultaneous events:
  - i_rreq/i_wreq outside IDLE of their own FSM: ignored.
  - Read and write windows are independent and may overlap.
  - No forwarding: each read word reflects RAM contents at the time of its o_ren.
- Arithmetic: word index counts 0..32/W-1 then wraps to 0; bit counter 5-bit, wraps 31->0 at window end.

Test Plan:
- Reset, then idle for 10 cycles -> o_wen, o_ren, o_ready, o_wbusy, o_rdata0/1 all 0.
- W=2: i_wreq wreg0=5, wen0=1, wen1=0, serial data 0xDEADBEEF -> 16 writes to addresses {5,0..15}, data 2'b11,2'b11,2'b10,2'b11,... (LSB pair first); o_wbusy falls after T+34.
- Write wreg0=0 with 0xFFFFFFFF, then read rreg0=0 -> no o_wen; o_rdata0 is 0 for all 32 bits.
- Preload x3=0x12345678, x7=0x89ABCDEF; i_rreq at T -> o_ready at T+3; o_rdata0/1 serialise both values LSB-first over T+4..T+35 with no gaps.
- Overlap: i_wreq to x9 and i_rreq of x3/x7 two cycles later -> read streams unaffected; x9 words written correctly; extra i_rreq mid-stream ignored.
- Assert i_rst at write bit 10 -> no o_wen after the reset cycle; next i_wreq works normally from bit 0.

Source files
------------

// File: rtl/serv_rf_ram_bridge.sv
// rtl/serv_rf_ram_bridge.sv - bit-serial register file port to W-bit 1R1W RAM bridge
//
// Ports:
//   clk, i_rst                     clock, synchronous active-high reset
//   i_wreq, i_wreg0/1, i_wen0/1    start of a 32-bit serial write window (two channels)
//   i_wdata0/1                     serial write bits, LSB first
//   o_wbusy                        write window or its trailing RAM writes in progress
//   i_rreq, i_rreg0/1              start of a two-register serial read
//   o_ready                        pulse one cycle before the first read bit
//   o_rdata0/1                     serial read bits, LSB first
//   o_waddr, o_wdata, o_wen        RAM write port
//   o_raddr, o_ren, i_rdata        RAM read port (data valid the cycle after o_ren)
module serv_rf_ram_bridge #(
  parameter int W        = 2,
  parameter int CSR_REGS = 4,
  parameter int AW       = $clog2((32 + CSR_REGS) * 32 / W)
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_wreq,
  input  logic [5:0]    i_wreg0,
  input  logic [5:0]    i_wreg1,
  input  logic          i_wen0,
  input  logic          i_wen1,
  input  logic          i_wdata0,
  input  logic          i_wdata1,
  output logic          o_wbusy,
  input  logic          i_rreq,
  input  logic [5:0]    i_rreg0,
  input  logic [5:0]    i_rreg1,
  output logic          o_ready,
  output logic          o_rdata0,
  output logic          o_rdata1,
  output logic [AW-1:0] o_waddr,
  output logic [W-1:0]  o_wdata,
  output logic          o_wen,
  output logic [AW-1:0] o_raddr,
  output logic          o_ren,
  input  logic [W-1:0]  i_rdata
);

  localparam int NREG = 32 + CSR_REGS;
  localparam int WPR  = 32 / W;
  localparam logic [4:0] WMASK = 5'(W - 1);

  // Word address is reg * words-per-register + word index, i.e. {reg, idx}.
  function automatic logic [AW-1:0] ram_addr(input logic [5:0] r, input int idx);
    int a;
    a = int'(r) * WPR + idx;
    return AW'(a);
  endfunction

  function automatic logic reg_ok(input logic [5:0] r);
    return int'(r) < NREG;
  endfunction

  // ---------------- write side ----------------
  typedef enum logic [1:0] {W_IDLE, W_SHIFT, W_FLUSH} wstate_t;

  wstate_t       wstate;
  logic [4:0]    wcnt;
  logic [5:0]    wreg0_q, wreg1_q;
  logic          wen0_q, wen1_q;
  logic [W-1:0]  sh0, sh1, hold1;
  logic [AW-1:0] hold1_addr;
  logic          pend1;

  logic [W-1:0]  sh0_next, sh1_next;
  logic          word_done;
  int            widx;

  always_comb begin
    sh0_next  = {i_wdata0, sh0[W-1:1]};
    sh1_next  = {i_wdata1, sh1[W-1:1]};
    word_done = (wstate == W_SHIFT) && ((wcnt & WMASK) == WMASK);
    widx      = int'(wcnt) / W;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wstate     <= W_IDLE;
      wcnt       <= '0;
      wreg0_q    <= '0;
      wreg1_q    <= '0;
      wen0_q     <= 1'b0;
      wen1_q     <= 1'b0;
      sh0        <= '0;
      sh1        <= '0;
      hold1      <= '0;
      hold1_addr <= '0;
      pend1      <= 1'b0;
      o_wbusy    <= 1'b0;
      o_wen      <= 1'b0;
      o_waddr    <= '0;
      o_wdata    <= '0;
    end else begin
      o_wen <= 1'b0;
      case (wstate)
        W_IDLE: begin
          if (i_wreq) begin
            wreg0_q <= i_wreg0;
            wreg1_q <= i_wreg1;
            // Suppression is decided once per window; x0 is never written.
            wen0_q  <= i_wen0 && (i_wreg0 != 6'd0) && reg_ok(i_wreg0);
            wen1_q  <= i_wen1 && reg_ok(i_wreg1);
            wcnt    <= '0;
            o_wbusy <= 1'b1;
            wstate  <= W_SHIFT;
          end
        end
        W_SHIFT: begin
          sh0  <= sh0_next;
          sh1  <= sh1_next;
          wcnt <= wcnt + 5'd1;
          if (wcnt == 5'd31) wstate <= W_FLUSH;
        end
        W_FLUSH: begin
          // Two cycles: channel 0 then channel 1 write of the last word.
          wcnt <= wcnt + 5'd1;
          if (wcnt == 5'd1) begin
            wcnt    <= '0;
            o_wbusy <= 1'b0;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase

      // Word completions are at least two cycles apart (W >= 2), so the
      // channel 1 write always has a free slot right after channel 0.
      if (word_done) begin
        o_wen      <= wen0_q;
        o_waddr    <= ram_addr(wreg0_q, widx);
        o_wdata    <= sh0_next;
        pend1      <= wen1_q;
        hold1      <= sh1_next;
        hold1_addr <= ram_addr(wreg1_q, widx);
      end else if (pend1) begin
        o_wen   <= 1'b1;
        o_waddr <= hold1_addr;
        o_wdata <= hold1;
        pend1   <= 1'b0;
      end
    end
  end

  // ---------------- read side ----------------
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;

  rstate_t       rstate;
  logic [5:0]    rcnt;      // cycles since the request, 0 at the first RAM read
  logic [5:0]    rreg0_q, rreg1_q;
  logic [W-1:0]  nxt0, sr0, sr1;

  int            rn;
  logic          fetch_next, in_stream, load_word, cap_rs1;
  logic [AW-1:0] fetch_addr;
  logic [W-1:0]  rs1_word, rs2_word;

  // Schedule per word k: rs1 read at rcnt=kW, rs2 at kW+1; rs1 data is
  // parked in nxt0 and both words enter the shifters at kW+2, exactly when
  // the rs2 data arrives.
  always_comb begin
    rn         = int'(rcnt) + 1;
    fetch_next = (rn < 32) && ((rn % W) < 2);
    fetch_addr = ram_addr(((rn % W) == 0) ? rreg0_q : rreg1_q, rn / W);
    in_stream  = (rcnt >= 6'd2) && (rcnt <= 6'd33);
    load_word  = in_stream && (((int'(rcnt) - 2) % W) == 0);
    cap_rs1    = ((int'(rcnt) % W) == 1) && (rcnt < 6'd32);
    rs1_word   = (rreg0_q == 6'd0) ? '0 : i_rdata;
    rs2_word   = (rreg1_q == 6'd0) ? '0 : i_rdata;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      rstate   <= R_IDLE;
      rcnt     <= '0;
      rreg0_q  <= '0;
      rreg1_q  <= '0;
      nxt0     <= '0;
      sr0      <= '0;
      sr1      <= '0;
      o_ren    <= 1'b0;
      o_raddr  <= '0;
      o_ready  <= 1'b0;
      o_rdata0 <= 1'b0;
      o_rdata1 <= 1'b0;
    end else begin
      o_ren   <= 1'b0;
      o_ready <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (i_rreq) begin
            rreg0_q <= i_rreg0;
            rreg1_q <= i_rreg1;
            rcnt    <= '0;
            o_ren   <= 1'b1;
            o_raddr <= ram_addr(i_rreg0, 0);
            rstate  <= R_FETCH;
          end
        end
        R_FETCH, R_STREAM: begin
          rcnt <= rcnt + 6'd1;
          if (fetch_next) begin
            o_ren   <= 1'b1;
            o_raddr <= fetch_addr;
          end
          if (cap_rs1) nxt0 <= rs1_word;
          if (rcnt == 6'd1) begin
            o_ready <= 1'b1;
            rstate  <= R_STREAM;
          end
          if (load_word) begin
            o_rdata0 <= nxt0[0];
            sr0      <= nxt0 >> 1;
            o_rdata1 <= rs2_word[0];
            sr1      <= rs2_word >> 1;
          end else if (in_stream) begin
            o_rdata0 <= sr0[0];
            sr0      <= sr0 >> 1;
            o_rdata1 <= sr1[0];
            sr1      <= sr1 >> 1;
          end else begin
            o_rdata0 <= 1'b0;
            o_rdata1 <= 1'b0;
          end
          if (rcnt == 6'd34) begin
            rcnt   <= '0;
            rstate <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_rf_ram_bridge.sv
// tb/tb_serv_rf_ram_bridge.sv - self-checking bench for serv_rf_ram_bridge (W=2)
module tb_serv_rf_ram_bridge;

  localparam int W  = 2;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_wreq = 1'b0, i_wen0 = 1'b0, i_wen1 = 1'b0, i_wdata0 = 1'b0, i_wdata1 = 1'b0;
  logic [5:0] i_wreg0 = '0, i_wreg1 = '0, i_rreg0 = '0, i_rreg1 = '0;
  logic i_rreq = 1'b0;
  logic o_wbusy, o_ready, o_rdata0, o_rdata1, o_wen, o_ren;
  logic [AW-1:0] o_waddr, o_raddr;
  logic [W-1:0] o_wdata, i_rdata;

  serv_rf_ram_bridge dut (
    .clk(clk), .i_rst(i_rst),
    .i_wreq(i_wreq), .i_wreg0(i_wreg0), .i_wreg1(i_wreg1),
    .i_wen0(i_wen0), .i_wen1(i_wen1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .o_wbusy(o_wbusy),
    .i_rreq(i_rreq), .i_rreg0(i_rreg0), .i_rreg1(i_rreg1),
    .o_ready(o_ready), .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
    .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen),
    .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(i_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM with one cycle read latency
  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [W-1:0] ram_q = '0;
  assign i_rdata = ram_q;
  always @(posedge clk) begin
    if (o_wen === 1'b1) mem[o_waddr] <= o_wdata;
    if (o_ren === 1'b1) ram_q <= mem[o_raddr];
  end

  // ---------------- model ----------------
  logic [31:0] regm [0:63];
  logic [AW-1:0] exp_wa [int];
  logic [W-1:0]  exp_wd [int];
  bit exp_rdy [int];
  bit exp_rd0 [int];
  bit exp_rd1 [int];
  int wb_lo = 1, wb_hi = 0;
  int ra_lo = 1, ra_hi = 0;
  int w_free = 0, r_free = 0;

  int total = 0, bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word k of a channel is complete after bit kW+W-1 (cycle t+kW+W) and is
  // written in the next cycle; channel 1 one cycle after channel 0.
  task automatic sched_write(input int t, input int r0, input int r1, input bit e0, input bit e1,
                             input logic [31:0] v0, input logic [31:0] v1);
    for (int k = 0; k < 32 / W; k++) begin
      int c0;
      c0 = t + (k + 1) * W + 1;
      if (e0 && r0 != 0 && r0 < 36) begin
        exp_wa[c0] = AW'(r0 * 16 + k);
        exp_wd[c0] = W'(v0 >> (W * k));
      end
      if (e1 && r1 < 36) begin
        exp_wa[c0 + 1] = AW'(r1 * 16 + k);
        exp_wd[c0 + 1] = W'(v1 >> (W * k));
      end
    end
    wb_lo = t + 1;
    wb_hi = t + 34;
    w_free = t + 35;
  endtask

  task automatic sched_read(input int t, input int r0, input int r1);
    logic [31:0] a, b;
    a = (r0 == 0) ? 32'h0 : regm[r0];
    b = (r1 == 0) ? 32'h0 : regm[r1];
    exp_rdy[t + 3] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      exp_rd0[t + 4 + i] = a[i];
      exp_rd1[t + 4 + i] = b[i];
    end
    ra_lo = t + 1;
    ra_hi = t + 32;
    r_free = t + 36;
  endtask

  task automatic model_reset(input int r);
    int ks[$];
    foreach (exp_wa[k]) if (k > r) ks.push_back(k);
    foreach (ks[j]) begin exp_wa.delete(ks[j]); exp_wd.delete(ks[j]); end
    ks.delete();
    foreach (exp_rdy[k]) if (k > r) ks.push_back(k);
    foreach (ks[j]) exp_rdy.delete(ks[j]);
    ks.delete();
    foreach (exp_rd0[k]) if (k > r) ks.push_back(k);
    foreach (ks[j]) begin exp_rd0.delete(ks[j]); exp_rd1.delete(ks[j]); end
    if (wb_hi > r) wb_hi = r;
    if (ra_hi > r) ra_hi = r;
    w_free = r + 1;
    r_free = r + 1;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("wen", o_wen, exp_wa.exists(cyc));
      if (exp_wa.exists(cyc)) begin
        chk("waddr", o_waddr, exp_wa[cyc]);
        chk("wdata", o_wdata, exp_wd[cyc]);
      end
      chk("wbusy", o_wbusy, (cyc >= wb_lo && cyc <= wb_hi));
      if (!(cyc >= ra_lo && cyc <= ra_hi)) chk("ren_quiet", o_ren, 0);
      chk("ready", o_ready, exp_rdy.exists(cyc));
      chk("rdata0", o_rdata0, exp_rd0.exists(cyc) ? exp_rd0[cyc] : 1'b0);
      chk("rdata1", o_rdata1, exp_rd1.exists(cyc) ? exp_rd1[cyc] : 1'b0);
    end
  end

  // capture for literal pins
  logic [11:0] wlog [$];
  int cap_t = -100;
  int rdy_cyc = -1;
  logic [31:0] cap0 = '0, cap1 = '0;
  always @(negedge clk) begin
    if (chk_on && o_wen === 1'b1) wlog.push_back({o_waddr, o_wdata});
    if (o_ready === 1'b1) rdy_cyc = cyc;
    if (cyc >= cap_t + 4 && cyc <= cap_t + 35) begin
      cap0[cyc - cap_t - 4] = o_rdata0;
      cap1[cyc - cap_t - 4] = o_rdata1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_write(input int r0, input int r1, input bit e0, input bit e1,
                          input logic [31:0] v0, input logic [31:0] v1, input int abort_bit);
    int t;
    bit acc;
    t = cyc;
    acc = (cyc >= w_free);
    i_wreq = 1'b1; i_wreg0 = 6'(r0); i_wreg1 = 6'(r1); i_wen0 = e0; i_wen1 = e1;
    if (acc) sched_write(t, r0, r1, e0, e1, v0, v1);
    tick();
    i_wreq = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == abort_bit) begin
        i_rst = 1'b1;
        model_reset(cyc);
        tick();
        i_rst = 1'b0;
        return;
      end
      i_wdata0 = v0[i];
      i_wdata1 = v1[i];
      tick();
    end
    i_wdata0 = 1'b0;
    i_wdata1 = 1'b0;
    if (acc) begin
      if (e0 && r0 != 0 && r0 < 36) regm[r0] = v0;
      if (e1 && r1 < 36) regm[r1] = v1;
    end
  endtask

  task automatic do_read(input int r0, input int r1, input bit capture);
    if (cyc >= r_free) sched_read(cyc, r0, r1);
    if (capture) cap_t = cyc;
    i_rreq = 1'b1; i_rreg0 = 6'(r0); i_rreg1 = 6'(r1);
    tick();
    i_rreq = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = (a < 16) ? 2'b11 : 2'b00;
    for (int r = 0; r < 64; r++) regm[r] = 32'h0;
    repeat (4) tick();
    i_rst = 1'b0;
    chk_on = 1'b1;
    repeat (10) tick();

    // packing of x5, channel 1 disabled
    wlog.delete();
    do_write(5, 6, 1'b1, 1'b0, 32'hDEADBEEF, 32'hFFFFFFFF, 99);
    repeat (3) tick();
    chk("pin_wcount", wlog.size(), 16);
    if (wlog.size() >= 4) begin
      chk("pin_w0", wlog[0], {10'd80, 2'b11});
      chk("pin_w1", wlog[1], {10'd81, 2'b11});
      chk("pin_w2", wlog[2], {10'd82, 2'b10});
      chk("pin_w3", wlog[3], {10'd83, 2'b11});
    end

    // x0 is never written and always reads zero
    wlog.delete();
    do_write(0, 0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 99);
    repeat (3) tick();
    chk("pin_x0_nowrite", wlog.size(), 0);
    do_read(0, 5, 1'b1);
    repeat (40) tick();
    chk("pin_x0_read", cap0, 32'h0);
    chk("pin_x5_read", cap1, 32'hDEADBEEF);

    // preload x3 (channel 0) and x7 (channel 1), then read both
    do_write(3, 7, 1'b1, 1'b1, 32'h12345678, 32'h89ABCDEF, 99);
    repeat (3) tick();
    do_read(3, 7, 1'b1);
    repeat (40) tick();
    chk("pin_rd0", cap0, 32'h12345678);
    chk("pin_rd1", cap1, 32'h89ABCDEF);
    chk("pin_ready_lat", rdy_cyc - cap_t, 3);

    // overlapping write and read, plus a stray read request mid-stream
    fork
      do_write(9, 0, 1'b1, 1'b0, 32'hA5C30F96, 32'h0, 99);
      begin
        repeat (2) tick();
        do_read(3, 7, 1'b0);
        repeat (10) tick();
        do_read(1, 2, 1'b0);
      end
    join
    repeat (40) tick();
    do_read(9, 3, 1'b1);
    repeat (40) tick();
    chk("pin_x9_read", cap0, 32'hA5C30F96);

    // reset in the middle of a write window, then a clean window
    do_write(11, 0, 1'b1, 1'b0, 32'h13579BDF, 32'h0, 10);
    repeat (3) tick();
    do_write(12, 40, 1'b1, 1'b1, 32'h0BADF00D, 32'hFFFF0000, 99);
    repeat (3) tick();
    do_read(12, 9, 1'b1);
    repeat (40) tick();
    chk("pin_x12_read", cap0, 32'h0BADF00D);

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
